// File: rtl/stream_demux_1to2.sv
// Stream 1-to-2 demultiplexer: each accepted input word is routed by in_sel
// into one of two independent first-word-fall-through FIFOs.
module stream_demux_1to2 #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_sel,
    output logic                   out0_valid,
    input  logic                   out0_ready,
    output logic [WIDTH-1:0]       out0_data,
    output logic                   out1_valid,
    input  logic                   out1_ready,
    output logic [WIDTH-1:0]       out1_data,
    output logic [$clog2(DEPTH):0] count0,
    output logic [$clog2(DEPTH):0] count1
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       ready_out;
    logic [1:0]       valid_out;
    logic [CW-1:0]    count [2];
    logic [WIDTH-1:0] head  [2];

    assign ready_out = {out1_ready, out0_ready};

    // Full FIFO blocks the push even if it pops on the same edge.
    assign in_ready = (count[in_sel] != FULL);

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [WIDTH-1:0] mem [DEPTH];
        logic [AW-1:0]    wr_ptr;
        logic [AW-1:0]    rd_ptr;
        logic [CW-1:0]    cnt;

        assign valid_out[c] = (cnt != '0);
        assign push[c]      = in_valid && in_ready && (in_sel == 1'(c));
        assign pop[c]       = valid_out[c] && ready_out[c];
        assign head[c]      = mem[rd_ptr];
        assign count[c]     = cnt;

        // Storage is not reset; clearing the pointers and count is enough.
        always_ff @(posedge clk) begin
            if (push[c]) begin
                mem[wr_ptr] <= in_data;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push[c]) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop[c]) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({push[c], pop[c]})
                    2'b10:   cnt <= cnt + CW'(1);
                    2'b01:   cnt <= cnt - CW'(1);
                    default: cnt <= cnt;
                endcase
            end
        end
    end

    assign out0_valid = valid_out[0];
    assign out1_valid = valid_out[1];
    assign out0_data  = head[0];
    assign out1_data  = head[1];
    assign count0     = count[0];
    assign count1     = count[1];

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Directed bench for stream_demux_1to2 (WIDTH=8, DEPTH=4): routing, fill/drain,
// channel independence, full-with-pop, wrap-around and mid-operation reset.
module tb_stream_demux_1to2;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_sel;
    logic       out0_valid;
    logic       out0_ready;
    logic [7:0] out0_data;
    logic       out1_valid;
    logic       out1_ready;
    logic [7:0] out1_data;
    logic [2:0] count0;
    logic [2:0] count1;

    int checks   = 0;
    int failures = 0;

    stream_demux_1to2 #(.WIDTH(8), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .count0     (count0),
        .count1     (count1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic sel, input logic [7:0] data);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        #1;
        chk("push_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int sent;
        int rcv;
        int cyc;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = 1'b0;
        out0_ready = 1'b0; out1_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_count0", 32'(count0), 32'd0);
        chk("rst_count1", 32'(count1), 32'd0);
        chk("rst_valid0", 32'(out0_valid), 32'd0);
        chk("rst_valid1", 32'(out1_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);

        // basic routing
        out0_ready = 1'b1; out1_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'hA1;
        #1;
        chk("rt_ready0", 32'(in_ready), 32'd1);
        chk("rt_nobypass", 32'(out0_valid), 32'd0);
        tick();
        in_sel = 1'b1; in_data = 8'hB2;
        #1;
        chk("rt_v0", 32'(out0_valid), 32'd1);
        chk("rt_d0", 32'(out0_data), 32'hA1);
        chk("rt_v1_early", 32'(out1_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        #1;
        chk("rt_v0_gone", 32'(out0_valid), 32'd0);
        chk("rt_v1", 32'(out1_valid), 32'd1);
        chk("rt_d1", 32'(out1_data), 32'hB2);
        tick();
        chk("rt_v1_gone", 32'(out1_valid), 32'd0);
        chk("rt_cnt1", 32'(count1), 32'd0);

        // fill and order
        out0_ready = 1'b0; out1_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(1'b0, 8'(8'h10 + i));
        chk("fill_cnt0", 32'(count0), 32'd4);
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'hEE;
        #1;
        chk("fill_full_ready", 32'(in_ready), 32'd0);
        tick();
        chk("fill_hold_cnt0", 32'(count0), 32'd4);
        in_valid = 1'b0;
        out0_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("fill_v0", 32'(out0_valid), 32'd1);
            chk("fill_d0", 32'(out0_data), 32'(8'h10 + i));
            tick();
        end
        chk("fill_empty_cnt0", 32'(count0), 32'd0);
        chk("fill_empty_v0", 32'(out0_valid), 32'd0);

        // independence
        out0_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(1'b0, 8'(8'h20 + i));
        out1_ready = 1'b1;
        push_word(1'b1, 8'h55);
        #1;
        chk("ind_v1", 32'(out1_valid), 32'd1);
        chk("ind_d1", 32'(out1_data), 32'h55);
        chk("ind_cnt0", 32'(count0), 32'd4);
        chk("ind_d0", 32'(out0_data), 32'h20);
        tick();
        chk("ind_v1_gone", 32'(out1_valid), 32'd0);
        chk("ind_cnt0_after", 32'(count0), 32'd4);

        // full plus simultaneous pop
        out1_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h24; out0_ready = 1'b1;
        #1;
        chk("fp_ready", 32'(in_ready), 32'd0);
        tick();
        chk("fp_cnt_pop", 32'(count0), 32'd3);
        chk("fp_d_pop", 32'(out0_data), 32'h21);
        chk("fp_ready2", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("fp_cnt_both", 32'(count0), 32'd3);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("fp_drain", 32'(out0_data), 32'(8'h22 + i));
            tick();
        end
        chk("fp_empty", 32'(count0), 32'd0);

        // wrap-around on channel 1 with toggling ready
        out0_ready = 1'b0;
        sent = 0; rcv = 0; cyc = 0;
        while (rcv < 10 && cyc < 200) begin
            in_valid   = (sent < 10);
            in_sel     = 1'b1;
            in_data    = 8'(sent);
            out1_ready = cyc[0];
            #1;
            if (out1_valid && out1_ready) begin
                chk("wrap_data", 32'(out1_data), 32'(rcv));
                rcv++;
            end
            if (in_valid && in_ready) sent++;
            tick();
            cyc++;
        end
        in_valid = 1'b0; out1_ready = 1'b0;
        #1;
        chk("wrap_rcv", 32'(rcv), 32'd10);
        chk("wrap_cnt1", 32'(count1), 32'd0);

        // reset mid-operation, with a handshake in the reset cycle
        push_word(1'b0, 8'h30);
        push_word(1'b0, 8'h31);
        push_word(1'b1, 8'h40);
        push_word(1'b1, 8'h41);
        push_word(1'b1, 8'h42);
        chk("mr_cnt0", 32'(count0), 32'd2);
        chk("mr_cnt1", 32'(count1), 32'd3);
        rst = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h77; out0_ready = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0; out0_ready = 1'b0;
        #1;
        chk("mr_cnt0_clr", 32'(count0), 32'd0);
        chk("mr_cnt1_clr", 32'(count1), 32'd0);
        chk("mr_v0", 32'(out0_valid), 32'd0);
        chk("mr_v1", 32'(out1_valid), 32'd0);
        chk("mr_ready", 32'(in_ready), 32'd1);
        push_word(1'b0, 8'h66);
        #1;
        chk("mr_first_v0", 32'(out0_valid), 32'd1);
        chk("mr_first_d0", 32'(out0_data), 32'h66);
        chk("mr_first_cnt0", 32'(count0), 32'd1);
        out0_ready = 1'b1; out1_ready = 1'b1;
        tick();
        chk("mr_end_cnt0", 32'(count0), 32'd0);
        chk("mr_end_v0", 32'(out0_valid), 32'd0);
        chk("mr_end_v1", 32'(out1_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stream_demux_1to2.md
STREAM_DEMUX_1TO2 -- requirements
Module: stream_demux_1to2

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width of the input and both outputs.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the entries per output FIFO; legal values are powers of two, 2..16.

Interface
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset sampled on the rising edge of clk.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning the upstream source offers a word.
REQ-006 The block SHALL have port in_ready, output, 1 bit, meaning the block can accept the offered word this cycle.
REQ-007 The block SHALL have port in_data, input, WIDTH bits, the offered data word.
REQ-008 The block SHALL have port in_sel, input, 1 bit, the destination: 0 routes to channel 0, 1 routes to channel 1.
REQ-009 The block SHALL have ports out0_valid (output, 1 bit), out0_ready (input, 1 bit) and out0_data (output, WIDTH bits) for the channel 0 stream.
REQ-010 The block SHALL have ports out1_valid (output, 1 bit), out1_ready (input, 1 bit) and out1_data (output, WIDTH bits) for the channel 1 stream.
REQ-011 The block SHALL have ports count0 and count1, outputs, clog2(DEPTH)+1 bits each, giving the current occupancy of each FIFO.

Function
REQ-012 The block SHALL contain two independent circular FIFOs, FIFO0 and FIFO1, each DEPTH entries deep, with a write pointer, a read pointer and an occupancy count.
REQ-013 The in_ready output SHALL be combinational and equal (count[in_sel] != DEPTH).
REQ-014 An input transfer SHALL occur on a rising edge where in_valid and in_ready are both 1; the block then writes in_data into FIFO[in_sel] and advances that FIFO's write pointer.
REQ-015 On a transfer, the block SHALL leave the non-selected FIFO unchanged, so data is never duplicated or written to both channels.
REQ-016 For each channel n, outn_valid SHALL be equal to (countn != 0).
REQ-017 For each channel n, outn_data SHALL always show the entry at the read pointer (first-word fall-through).
REQ-018 When outn_valid is 0, outn_data is don't-care and the bench SHALL NOT check it.
REQ-019 For each channel n, a pop SHALL occur on a rising edge where outn_valid and outn_ready are both 1, and the read pointer advances by 1.
REQ-020 Latency SHALL be one cycle: a word accepted at edge k into an empty FIFO appears with outn_valid=1 in the cycle following edge k; there is no same-cycle bypass.
REQ-021 Pointers SHALL wrap modulo DEPTH; DEPTH consecutive writes return the write pointer to its start position.
REQ-022 Simultaneous push and pop on the same FIFO SHALL leave its count unchanged and move both pointers.
REQ-023 On a full FIFO, the push is blocked by in_ready=0 even if a pop occurs in the same cycle; a pop-freed slot is usable from the next cycle.
REQ-024 A pop on an empty FIFO is impossible because outn_valid=0; outn_ready SHALL then be ignored.
REQ-025 The channels SHALL be fully independent: backpressure on one channel SHALL NOT stall words destined for the other channel.
REQ-026 Word order SHALL be preserved within each channel; no ordering is defined between the two channels.
REQ-027 If upstream holds in_valid=1 while in_ready=0, the block SHALL NOT consume the word; it is accepted once in_ready returns to 1.
REQ-028 The count outputs SHALL be registered and SHALL update on the same edge as the push or pop.

Reset
REQ-029 While rst=1 at a rising edge, the block SHALL clear all pointers and counts to 0, which gives out0_valid=0, out1_valid=0, count0=0, count1=0 and in_ready=1.
REQ-030 FIFO storage contents SHALL NOT be reset.
REQ-031 Reset asserted mid-operation SHALL discard all stored words.
REQ-032 A handshake in the reset cycle SHALL have no effect.
REQ-033 The first transfer after reset SHALL be possible on the first edge where rst=0.

Verification
REQ-034 Bench scenario, basic routing: after reset, send 0xA1 with sel=0 and 0xB2 with sel=1, with both out_ready=1 -> 0xA1 appears only on out0 and 0xB2 appears only on out1, each one cycle after acceptance.
REQ-035 Bench scenario, fill and order: with out0_ready=0, send 0x10,0x11,0x12,0x13 with sel=0 -> count0=4, and in_ready=0 whenever in_sel=0; then set out0_ready=1 -> out0 emits 0x10..0x13 in order and count0 returns to 0.
REQ-036 Bench scenario, independence: FIFO0 is full and out0_ready=0; send 0x55 with sel=1 -> in_ready=1, the word is accepted and out1 emits 0x55; FIFO0 is unchanged.
REQ-037 Bench scenario, full plus simultaneous pop: FIFO0 is full, in_valid=1, in_sel=0, out0_ready=1 -> that edge pops only and count0 goes 4->3; on the next edge push and pop together and count0 stays 3.
REQ-038 Bench scenario, wrap-around: stream 10 words (0x00..0x09) through channel 1 with out1_ready toggling every cycle -> output order is exact, with no loss or duplicate.
REQ-039 Bench scenario, reset mid-operation: with count0=2 and count1=3, assert rst for one cycle -> next cycle shows count0=count1=0, both out_valid=0 and in_ready=1; the old data is never emitted.
